coil_drive_sequencer: RTL and testbench

- Sequences the mote's current loop during the scan period: accepts a 4-bit scan configuration from the metadata decoder, then drives positive/negative loop current, switching polarity on each DATA_IN edge pulse.
- Inserts break-before-make dead time between polarities, counts half-periods, ends the scan after the configured count, and aborts on an edge-gap watchdog.
- Sits between the edge detector / metadata FSM and the loop H-bridge enables.

---
 rtl/coil_drive_sequencer.sv | 152 +++++++++++++++
 tb/tb_coil_drive_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coil_drive_sequencer.sv
// Mote loop-current sequencer: config handshake, break-before-make polarity switching,
// half-period counting and edge-gap watchdog. Optional continuous mode: COIL_SEQ_CONT_EN.
module coil_drive_sequencer #(
  parameter int unsigned DEAD_CYCLES = 8,
  parameter int unsigned TICK_DIV    = 10000,
  parameter int unsigned TIMEOUT_MS  = 1000
) (
  input  logic       CLK_IN,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_data,
  output logic       cfg_ready,
  input  logic       edge_in,
  output logic       drv_pos,
  output logic       drv_neg,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       overrun,
  output logic [4:0] half_cnt
);

  localparam int unsigned TW = $clog2(TICK_DIV + 1);
  localparam int unsigned MW = $clog2(TIMEOUT_MS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DEAD, S_DRIVE, S_DONE} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [MW-1:0] ms_cnt;
  logic [7:0]    dead_cnt;
  logic [4:0]    target;
  logic          pol;
  logic          cont;
  logic          tick;
  logic          wd_hit;

  assign tick   = (32'(tick_cnt) == TICK_DIV - 1);
  // Abort lands on the tick that would bring the ms count to TIMEOUT_MS.
  assign wd_hit = tick && ((32'(ms_cnt) + 32'd1) >= TIMEOUT_MS);

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      state       <= S_IDLE;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      drv_pos     <= 1'b0;
      drv_neg     <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      half_cnt    <= '0;
      tick_cnt    <= '0;
      ms_cnt      <= '0;
      dead_cnt    <= '0;
      target      <= '0;
      pol         <= 1'b0;
      cont        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) begin
        tick_cnt <= '0;
        if (32'(ms_cnt) < TIMEOUT_MS) ms_cnt <= ms_cnt + MW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      case (state)
        S_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            state       <= S_ARMED;
            cfg_ready   <= 1'b0;
            busy        <= 1'b1;
            target      <= {1'b0, cfg_data[2:0], 1'b0} + 5'd2;
            pol         <= cfg_data[3];
`ifdef COIL_SEQ_CONT_EN
            cont        <= (cfg_data[2:0] == 3'b111);
`else
            cont        <= 1'b0;
`endif
            half_cnt    <= '0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            tick_cnt    <= '0;
            ms_cnt      <= '0;
          end
        end

        S_ARMED, S_DRIVE: begin
          // Edge is checked first so it wins over a coincident watchdog tick.
          if (edge_in) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
            dead_cnt <= 8'(DEAD_CYCLES);
            drv_pos  <= 1'b0;
            drv_neg  <= 1'b0;
            if (state == S_ARMED) begin
              state <= S_DEAD;
            end else begin
              if (!(cont && half_cnt == 5'd31)) half_cnt <= half_cnt + 5'd1;
              if (!cont && (half_cnt + 5'd1) == target) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_DEAD;
                pol   <= ~pol;
              end
            end
          end else if (wd_hit) begin
            drv_pos <= 1'b0;
            drv_neg <= 1'b0;
            if (cont) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_IDLE;
              cfg_ready   <= 1'b1;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
        end

        S_DEAD: begin
          if (edge_in) overrun <= 1'b1;
          if (dead_cnt == 8'd0) begin
            state   <= S_DRIVE;
            drv_pos <= ~pol;
            drv_neg <= pol;
          end else begin
            dead_cnt <= dead_cnt - 8'd1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          drv_pos   <= 1'b0;
          drv_neg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coil_drive_sequencer.sv
// Bench for coil_drive_sequencer: timestamp-based reference model checked every cycle,
// plus literal timing pins. Exercises continuous mode when COIL_SEQ_CONT_EN is defined.
module tb_coil_drive_sequencer;

  localparam int unsigned DEAD = 4;
  localparam int unsigned TDIV = 10;
  localparam int unsigned TMO  = 3;
  localparam int          TT   = TDIV * TMO;
`ifdef COIL_SEQ_CONT_EN
  localparam logic [3:0] MAXCFG = 4'b1110;
  localparam int         MAXH   = 14;
`else
  localparam logic [3:0] MAXCFG = 4'b1111;
  localparam int         MAXH   = 16;
`endif

  logic       CLK_IN = 1'b0;
  logic       rst, cfg_valid, edge_in;
  logic [3:0] cfg_data;
  logic       cfg_ready, drv_pos, drv_neg, busy, done, timeout_err, overrun;
  logic [4:0] half_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int done_seen = 0;

  always #5 CLK_IN = ~CLK_IN;

  coil_drive_sequencer #(
    .DEAD_CYCLES(DEAD),
    .TICK_DIV   (TDIV),
    .TIMEOUT_MS (TMO)
  ) dut (
    .CLK_IN     (CLK_IN),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .edge_in    (edge_in),
    .drv_pos    (drv_pos),
    .drv_neg    (drv_neg),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .overrun    (overrun),
    .half_cnt   (half_cnt)
  );

  // Inputs as the DUT saw them at the last rising edge.
  logic       s_rst, s_valid, s_edge;
  logic [3:0] s_data;
  always @(posedge CLK_IN) begin
    s_rst   <= rst;
    s_valid <= cfg_valid;
    s_edge  <= edge_in;
    s_data  <= cfg_data;
  end

  // Reference model: scan described by timestamps (last watchdog clear, drive-on cycle).
  int cyc = 0;
  bit m_ok = 0, m_busy = 0, m_fin = 0, m_started = 0, m_driving = 0, m_pol = 0, m_cont = 0;
  int m_clear = 0, m_on_at = 0, m_half = 0, m_target = 0;
  int e_ready = 1, e_busy = 0, e_pos = 0, e_neg = 0, e_done = 0, e_to = 0, e_ovr = 0, e_half = 0;

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    int since;
    cyc++;
    if (s_rst === 1'b1) begin
      m_ok = 1; m_busy = 0; m_fin = 0; m_started = 0; m_driving = 0;
      e_ready = 1; e_busy = 0; e_pos = 0; e_neg = 0; e_done = 0; e_to = 0; e_ovr = 0; e_half = 0;
      return;
    end
    if (!m_ok) return;
    e_done = 0;
    if (m_fin) begin
      m_fin = 0; m_busy = 0; e_ready = 1; e_busy = 0;
    end else if (!m_busy) begin
      if (s_valid) begin
        m_busy = 1; m_started = 0; m_driving = 0; m_clear = cyc;
        m_pol = s_data[3];
        m_target = 2 * (int'(s_data[2:0]) + 1);
`ifdef COIL_SEQ_CONT_EN
        m_cont = (s_data[2:0] == 3'b111);
`else
        m_cont = 0;
`endif
        e_ready = 0; e_busy = 1; e_half = 0; e_to = 0; e_ovr = 0;
      end
    end else if (m_started && !m_driving) begin
      if (s_edge) e_ovr = 1;
      if (cyc == m_on_at) begin
        m_driving = 1;
        e_pos = m_pol ? 0 : 1;
        e_neg = m_pol ? 1 : 0;
      end
    end else begin
      since = cyc - m_clear;
      if (s_edge) begin
        m_clear = cyc;
        e_pos = 0; e_neg = 0;
        m_on_at = cyc + DEAD + 1;
        if (!m_started) begin
          m_started = 1;
        end else begin
          m_driving = 0;
          e_half = (m_cont && e_half == 31) ? 31 : e_half + 1;
          if (!m_cont && e_half == m_target) begin
            m_fin = 1; e_done = 1;
          end else begin
            m_pol = !m_pol;
          end
        end
      end else if (since >= TT && since % TDIV == 0) begin
        e_pos = 0; e_neg = 0; m_driving = 0;
        if (m_cont) begin
          m_fin = 1; e_done = 1;
        end else begin
          m_busy = 0; e_busy = 0; e_ready = 1; e_to = 1;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK_IN);
      model_step();
      if (m_ok) begin
        chk("cfg_ready",   32'(cfg_ready),   e_ready);
        chk("busy",        32'(busy),        e_busy);
        chk("drv_pos",     32'(drv_pos),     e_pos);
        chk("drv_neg",     32'(drv_neg),     e_neg);
        chk("done",        32'(done),        e_done);
        chk("timeout_err", 32'(timeout_err), e_to);
        chk("overrun",     32'(overrun),     e_ovr);
        chk("half_cnt",    32'(half_cnt),    e_half);
        chk("no_overlap",  32'(drv_pos & drv_neg), 0);
        if (done === 1'b1) done_seen++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK_IN);
  endtask

  task automatic send_cfg(input logic [3:0] d);
    @(negedge CLK_IN);
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(negedge CLK_IN);
    cfg_valid = 1'b0;
  endtask

  // Edge is sampled `gap` rising edges after the call; returns just after that edge.
  task automatic pulse(input int gap);
    repeat (gap - 1) @(negedge CLK_IN);
    edge_in = 1'b1;
    @(negedge CLK_IN);
    edge_in = 1'b0;
  endtask

  initial begin
    int lat;
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = 4'b0000; edge_in = 1'b0;
    wait_cyc(3);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_drives",    32'({drv_pos, drv_neg}), 0);
    chk("rst_half",      32'(half_cnt), 0);
    rst = 1'b0;

    // Basic scan, target 2
    send_cfg(4'b0000);
    chk("hs_ready_low", 32'(cfg_ready), 0);
    chk("hs_busy",      32'(busy), 1);
    wait_cyc(3);
    chk("armed_drives", 32'({drv_pos, drv_neg}), 0);
    pulse(2);
    wait_cyc(4);
    chk("pos_not_yet",  32'(drv_pos), 0);
    wait_cyc(1);
    chk("pos_on_5",     32'(drv_pos), 1);
    pulse(15);
    chk("pos_off",      32'(drv_pos), 0);
    wait_cyc(5);
    chk("neg_on_5",     32'({drv_pos, drv_neg}), 1);
    pulse(15);
    chk("done_pulse",   32'(done), 1);
    wait_cyc(2);
    chk("basic_half",   32'(half_cnt), 2);
    chk("basic_ready",  32'(cfg_ready), 1);
    chk("basic_done_n", 32'(done_seen), 1);

    // Negative start, maximum count
    send_cfg(MAXCFG);
    pulse(3);
    wait_cyc(5);
    chk("max_first_neg", 32'({drv_pos, drv_neg}), 1);
    pulse(7);
    for (int i = 1; i < MAXH; i++) pulse(12);
    chk("max_done", 32'(done), 1);
    wait_cyc(2);
    chk("max_half",   32'(half_cnt), MAXH);
    chk("max_done_n", 32'(done_seen), 2);

    // Overrun: edge two cycles into dead time
    send_cfg(4'b0001);
    pulse(3);
    pulse(2);
    chk("ovr_set", 32'(overrun), 1);
    wait_cyc(2);
    chk("ovr_pos_wait", 32'(drv_pos), 0);
    wait_cyc(1);
    chk("ovr_pos_on5",  32'(drv_pos), 1);
    pulse(15);
    for (int i = 0; i < 3; i++) pulse(20);
    chk("ovr_done", 32'(done), 1);
    wait_cyc(2);
    chk("ovr_sticky", 32'(overrun), 1);
    chk("ovr_half",   32'(half_cnt), 4);
    chk("ovr_done_n", 32'(done_seen), 3);

    // Watchdog abort in DRIVE
    send_cfg(4'b0000);
    chk("ovr_cleared", 32'(overrun), 0);
    pulse(2);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK_IN);
      if (timeout_err === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("wd_latency", 32'(lat), TT);
    chk("wd_drives",  32'({drv_pos, drv_neg}), 0);
    chk("wd_busy",    32'(busy), 0);
    wait_cyc(2);
    chk("wd_no_done", 32'(done_seen), 3);
    send_cfg(4'b0000);
    chk("wd_cleared", 32'(timeout_err), 0);
    wait_cyc(TT + 5);
    chk("wd_armed_abort", 32'(timeout_err), 1);

`ifdef COIL_SEQ_CONT_EN
    send_cfg(4'b0111);
    pulse(3);
    for (int i = 1; i < 40; i++) pulse(12);
    chk("cont_sat", 32'(half_cnt), 31);
    lat = -1;
    for (int i = 1; i <= TT + 10; i++) begin
      @(negedge CLK_IN);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("cont_done_seen", 32'(lat > 0), 1);
    chk("cont_no_to",     32'(timeout_err), 0);
    wait_cyc(2);
    chk("cont_half_hold", 32'(half_cnt), 31);
`endif

    // Reset while driving
    send_cfg(4'b0000);
    pulse(3);
    wait_cyc(6);
    chk("mid_pos_on", 32'(drv_pos), 1);
    rst = 1'b1;
    @(negedge CLK_IN);
    rst = 1'b0;
    chk("mid_rst_drives", 32'({drv_pos, drv_neg}), 0);
    chk("mid_rst_ready",  32'(cfg_ready), 1);
    wait_cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
